comp_nbit_serial: RTL and testbench
===================================

Name: comp_nbit_serial

Overview:
- Multi-cycle magnitude comparator for two WIDTH-bit operands. It examines DIGIT bits per clock, MSB-first, and stops early at the first differing digit.
- Supports unsigned and two's-complement signed compare, selected per operation.
- Uses a start/busy/done handshake, so it can sit behind a controller or bus register file in place of the combinational 8-bit comparator when area matters more than latency.
- Results stay registered and valid until the next operation starts.

Parameters:
- WIDTH, 8, operand width in bits; must be >= 2.
- DIGIT, 2, bits compared per cycle; must divide WIDTH evenly. NDIG = WIDTH/DIGIT digit steps.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a compare; sampled only in IDLE or DONE.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; captured with start.
- a  input  WIDTH  operand A; captured with start.
- b  input  WIDTH  operand B; captured with start.
- busy  output  1  high while an accepted compare is in progress.
- done  output  1  one-cycle pulse when the result becomes valid.
- a_gt_b  output  1  registered result: A > B.
- a_eq_b  output  1  registered result: A == B.
- a_lt_b  output  1  registered result: A < B.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, busy=0, done=0, a_gt_b=a_eq_b=a_lt_b=0, digit counter=0, operand registers=0.
- Until the first completed compare after reset, all three result outputs are 0. After completion they are strictly one-hot.
- States: IDLE, CMP, DONE.
- IDLE, start=1 at edge k:
  - Capture a, b and signed_mode into internal shift registers.
  - Counter=0, go to CMP, busy=1 after edge k.
  - Result outputs clear to 0 at edge k.
- CMP, each edge, on the top DIGIT bits of the A and B shift registers:
  - Signed mode, counter==0 only: invert the MSB of both top digits before comparing. This places a negative operand below a non-negative one.
  - Digits differ: set a_gt_b or a_lt_b from the unsigned digit compare, clear the other two results, go to DONE.
  - Digits equal and counter==NDIG-1: set a_eq_b=1, go to DONE.
  - Digits equal otherwise: shift both registers left by DIGIT, counter+1, stay in CMP.
- Latency: if the first difference is in digit i (0 = most significant), done is high in the cycle after edge k+1+i, i.e. i+1 cycles after start is sampled. Maximum latency is NDIG cycles, for equal operands or a difference only in the last digit.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - Next edge: with start=0 go to IDLE; with start=1 capture a new operation exactly as from IDLE (back-to-back, no idle gap).
- start while in CMP: ignored. Captured operands and mode are unaffected, and no queueing occurs.
- Changes to a, b or signed_mode after capture have no effect on the operation in progress.
- Width rules:
  - The counter is clog2(NDIG) bits, minimum 1.
  - DIGIT==WIDTH is legal: single-cycle CMP with the signed inversion applied to that digit.
  - DIGIT==1 with signed mode: digit 0 is the sign bit alone, and the inverted compare applies to it.
- Reset asserted mid-operation: immediate abort to the reset values. No done pulse is produced, and the operation is not resumed after reset deasserts.
- busy and done are never high together.

Test Plan:
- WIDTH=8, DIGIT=2, unsigned, a=0xA5, b=0x3C, start one cycle -> digit 0 differs (10 vs 00); done exactly 1 cycle after start sampled; a_gt_b=1, a_eq_b=0, a_lt_b=0; results hold for 10 idle cycles.
- Same operands with signed_mode=1 (-91 vs 60) -> done after 1 cycle, a_lt_b=1. Also a=0x80, b=0x7F signed -> a_lt_b=1; unsigned -> a_gt_b=1.
- a=b=0x7E unsigned -> busy for 4 cycles, done in the 4th cycle after start, a_eq_b=1. Then a=0x12, b=0x13 -> a_lt_b=1 after 4 cycles (last-digit difference).
- Start pulsed again while busy, with different operands -> ignored; the original result is reported. Start held high through DONE -> the next compare begins with no gap, and the results clear on that edge.
- Reset asserted in the 2nd CMP cycle of an equal-operand compare -> busy, done and all results 0 immediately; no done pulse after release; next start behaves normally.
- Configurations WIDTH=16/DIGIT=1 and WIDTH=8/DIGIT=8: random 1000-op signed and unsigned sweep -> results match a reference compare; latency = first-differing-digit index + 1.

Source files
------------

// File: rtl/comp_nbit_serial.sv
// Digit-serial magnitude comparator, MSB-first with early exit.
// Signed/unsigned per operation, start/busy/done handshake.
module comp_nbit_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic             a_lt_b
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sm_q, sm_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic [DIGIT-1:0] da, db;
  logic             flip;

  // State, operand shifters, counter and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sm_q    <= 1'b0;
      cnt_q   <= '0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sm_q    <= sm_d;
      cnt_q   <= cnt_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
    end
  end

  // Top digits; in signed mode the first digit's MSB is inverted so
  // negative operands order below non-negative ones
  always_comb begin
    flip = sm_q && (cnt_q == '0);
    da   = a_q[WIDTH-1 -: DIGIT];
    db   = b_q[WIDTH-1 -: DIGIT];
    da[DIGIT-1] = da[DIGIT-1] ^ flip;
    db[DIGIT-1] = db[DIGIT-1] ^ flip;
  end

  // Next-state: capture on start, compare one digit per cycle
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sm_d    = sm_q;
    cnt_d   = cnt_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sm_d    = signed_mode;
          cnt_d   = '0;
          gt_d    = 1'b0;
          eq_d    = 1'b0;
          lt_d    = 1'b0;
          state_d = CMP;
        end else begin
          state_d = IDLE;
        end
      end
      CMP: begin
        if (da != db) begin
          gt_d    = (da > db);
          lt_d    = (da < db);
          eq_d    = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CW'(NDIG - 1)) begin
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          eq_d    = 1'b1;
          state_d = DONE;
        end else begin
          a_d   = a_q << DIGIT;
          b_d   = b_q << DIGIT;
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q == CMP);
  assign done   = (state_q == DONE);
  assign a_gt_b = gt_q;
  assign a_eq_b = eq_q;
  assign a_lt_b = lt_q;

endmodule

// File: tb/tb_comp_nbit_serial.sv
// Bench for comp_nbit_serial: vector table, corner sequences and
// random sweeps on 8/2, 16/1 and 8/8 configurations.
module tb_comp_nbit_serial;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  st  = '0;
  logic [2:0]  smv = '0;
  logic [7:0]  a0 = '0, b0 = '0;
  logic [15:0] a1 = '0, b1 = '0;
  logic [7:0]  a2 = '0, b2 = '0;
  logic [2:0]  bsy, dn, gt, eq, lt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  comp_nbit_serial #(.WIDTH(8), .DIGIT(2)) u0 (
    .clk(clk), .rst(rst), .start(st[0]), .signed_mode(smv[0]),
    .a(a0), .b(b0), .busy(bsy[0]), .done(dn[0]),
    .a_gt_b(gt[0]), .a_eq_b(eq[0]), .a_lt_b(lt[0]));

  comp_nbit_serial #(.WIDTH(16), .DIGIT(1)) u1 (
    .clk(clk), .rst(rst), .start(st[1]), .signed_mode(smv[1]),
    .a(a1), .b(b1), .busy(bsy[1]), .done(dn[1]),
    .a_gt_b(gt[1]), .a_eq_b(eq[1]), .a_lt_b(lt[1]));

  comp_nbit_serial #(.WIDTH(8), .DIGIT(8)) u2 (
    .clk(clk), .rst(rst), .start(st[2]), .signed_mode(smv[2]),
    .a(a2), .b(b2), .busy(bsy[2]), .done(dn[2]),
    .a_gt_b(gt[2]), .a_eq_b(eq[2]), .a_lt_b(lt[2]));

  // busy and done must never coincide on any instance
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (|(bsy & dn)) begin
        errors++;
        $display("FAIL busy_done_overlap: busy=%b done=%b required no overlap",
                 bsy, dn);
      end
    end
  end

  function automatic int wof(int w);
    return (w == 1) ? 16 : 8;
  endfunction

  function automatic int dof(int w);
    return (w == 0) ? 2 : (w == 1) ? 1 : 8;
  endfunction

  // Reference: plain integer compare of the operand values
  function automatic logic [2:0] ref_cmp(int w, bit sm,
                                         logic [15:0] a, logic [15:0] b);
    longint va, vb;
    va = longint'(a) & ((64'd1 << w) - 1);
    vb = longint'(b) & ((64'd1 << w) - 1);
    if (sm && a[w-1]) va = va - (64'sd1 <<< w);
    if (sm && b[w-1]) vb = vb - (64'sd1 <<< w);
    return {va > vb, va == vb, va < vb};
  endfunction

  // Reference latency: index of first differing digit plus one
  function automatic int ref_lat(int w, int d,
                                 logic [15:0] a, logic [15:0] b);
    longint m, x, y;
    m = (64'd1 << d) - 1;
    for (int i = 0; i < w / d; i++) begin
      x = (longint'(a) >> (w - (i + 1) * d)) & m;
      y = (longint'(b) >> (w - (i + 1) * d)) & m;
      if (x != y) return i + 1;
    end
    return w / d;
  endfunction

  function automatic logic [2:0] res(int w);
    return {gt[w], eq[w], lt[w]};
  endfunction

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic drive(int w, bit s, logic [15:0] av,
                       logic [15:0] bv, bit sm);
    st[w]  = s;
    smv[w] = sm;
    case (w)
      0: begin a0 = av[7:0]; b0 = bv[7:0]; end
      1: begin a1 = av; b1 = bv; end
      default: begin a2 = av[7:0]; b2 = bv[7:0]; end
    endcase
  endtask

  // Count negedges after the capture edge until done is seen
  task automatic wait_done(int w, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!dn[w] && lat < 40);
    if (!dn[w]) begin
      errors++;
      $display("FAIL timeout: inst %0d done not seen in 40 cycles", w);
    end
  endtask

  task automatic run_op(int w, logic [15:0] av, logic [15:0] bv, bit sm,
                        output logic [2:0] r, output int lat);
    @(negedge clk);
    drive(w, 1'b1, av, bv, sm);
    @(negedge clk);
    st[w] = 1'b0;
    wait_done(w, lat);
    r = res(w);
  endtask

  typedef struct {
    int          w;
    bit          sm;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  exp;
    int          lat;
  } vec_t;

  vec_t vt[$];

  initial begin
    logic [2:0] r;
    int         lat, ndone;
    logic [15:0] ra, rb;
    bit          rs;

    vt.push_back('{0, 0, 16'hA5, 16'h3C, 3'b100, 1});
    vt.push_back('{0, 1, 16'hA5, 16'h3C, 3'b001, 1});
    vt.push_back('{0, 1, 16'h80, 16'h7F, 3'b001, 1});
    vt.push_back('{0, 0, 16'h80, 16'h7F, 3'b100, 1});
    vt.push_back('{0, 0, 16'h7E, 16'h7E, 3'b010, 4});
    vt.push_back('{0, 0, 16'h12, 16'h13, 3'b001, 4});
    vt.push_back('{0, 1, 16'hFF, 16'hFE, 3'b100, 4});
    vt.push_back('{2, 1, 16'h80, 16'h7F, 3'b001, 1});
    vt.push_back('{2, 0, 16'hFF, 16'h00, 3'b100, 1});
    vt.push_back('{2, 1, 16'h05, 16'h05, 3'b010, 1});
    vt.push_back('{1, 1, 16'h8000, 16'h0001, 3'b001, 1});
    vt.push_back('{1, 0, 16'h0001, 16'h0000, 3'b100, 16});
    vt.push_back('{1, 1, 16'hFFFF, 16'hFFFF, 3'b010, 16});

    repeat (2) @(negedge clk);
    chk("reset_busy", int'(bsy), 0);
    chk("reset_done", int'(dn), 0);
    chk("reset_res", int'({gt, eq, lt}), 0);
    rst = 1'b0;

    foreach (vt[i]) begin
      run_op(vt[i].w, vt[i].a, vt[i].b, vt[i].sm, r, lat);
      chk($sformatf("vec%0d_res", i), int'(r), int'(vt[i].exp));
      chk($sformatf("vec%0d_lat", i), lat, vt[i].lat);
    end

    // results hold through idle cycles
    run_op(0, 16'hA5, 16'h3C, 1'b0, r, lat);
    repeat (10) @(negedge clk);
    chk("hold_res", int'(res(0)), 3'b100);
    chk("hold_busy", int'(bsy[0]), 0);
    chk("hold_done", int'(dn[0]), 0);

    // start while busy is ignored
    @(negedge clk);
    drive(0, 1'b1, 16'h7E, 16'h7E, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 16'h7E, 16'h7E, 1'b0);
    @(negedge clk);
    drive(0, 1'b1, 16'h00, 16'hFF, 1'b1);
    @(negedge clk);
    st[0] = 1'b0;
    lat = 2;
    wait_done(0, ndone);
    chk("ignore_res", int'(res(0)), 3'b010);
    chk("ignore_lat", lat + ndone, 4);

    // start held high through DONE: back-to-back compare
    @(negedge clk);
    drive(0, 1'b1, 16'h12, 16'h13, 1'b0);
    @(negedge clk);
    drive(0, 1'b1, 16'hA5, 16'h3C, 1'b0);
    wait_done(0, lat);
    chk("b2b_first_res", int'(res(0)), 3'b001);
    chk("b2b_first_lat", lat, 4);
    @(negedge clk);
    chk("b2b_busy", int'(bsy[0]), 1);
    chk("b2b_cleared", int'(res(0)), 0);
    @(negedge clk);
    st[0] = 1'b0;
    chk("b2b_done", int'(dn[0]), 1);
    chk("b2b_second_res", int'(res(0)), 3'b100);

    // reset in the 2nd CMP cycle of an equal compare
    @(negedge clk);
    drive(0, 1'b1, 16'h7E, 16'h7E, 1'b0);
    @(negedge clk);
    st[0] = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", int'(bsy[0]), 1);
    rst = 1'b1;
    #1;
    chk("rst_busy", int'(bsy[0]), 0);
    chk("rst_done", int'(dn[0]), 0);
    chk("rst_res", int'(res(0)), 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (dn[0] || bsy[0]) ndone++;
    end
    chk("rst_no_resume", ndone, 0);
    run_op(0, 16'h12, 16'h13, 1'b0, r, lat);
    chk("post_rst_res", int'(r), 3'b001);
    chk("post_rst_lat", lat, 4);

    // random sweeps on every configuration
    for (int w = 0; w < 3; w++) begin
      for (int n = 0; n < 1000; n++) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        if (wof(w) == 8) begin
          ra[15:8] = '0;
          rb[15:8] = '0;
        end
        case ($urandom_range(0, 3))
          0: rb = ra;
          1: rb = ra ^ (16'd1 << $urandom_range(0, wof(w) - 1));
          default: ;
        endcase
        rs = 1'($urandom);
        run_op(w, ra, rb, rs, r, lat);
        chk($sformatf("rnd%0d_%0d_res a=%h b=%h s=%0d", w, n, ra, rb, rs),
            int'(r), int'(ref_cmp(wof(w), rs, ra, rb)));
        chk($sformatf("rnd%0d_%0d_lat", w, n),
            lat, ref_lat(wof(w), dof(w), ra, rb));
      end
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
